// File: rtl/instr_decode_ctrl_if.sv
// ============================================================================
// Module      : instr_decode_ctrl_if
// Description : Decode-stage bundle: instruction/flag inputs, control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_decode_ctrl_if;
    logic [31:0] instr;
    logic [3:0]  ex_flags;
    logic        rt_zero;
    logic [19:0] cntrl;
    logic [19:0] cntrl_ex;
    logic [3:0]  flags;
    logic        stall;

    modport master (
        output instr, ex_flags, rt_zero,
        input  cntrl, cntrl_ex, flags, stall
    );

    modport slave (
        input  instr, ex_flags, rt_zero,
        output cntrl, cntrl_ex, flags, stall
    );
endinterface

`default_nettype wire

// File: rtl/instr_decode_ctrl.sv
// ============================================================================
// Module      : instr_decode_ctrl
// Description : Decode-stage control word, EX control register, NZCV register
//               and load-use / flag hazard stall. Macro FLAG_FWD_EN forwards
//               EX flags to B.cond instead of stalling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decode_ctrl (
    input  logic               clk,
    input  logic               reset,
    instr_decode_ctrl_if.slave bus
);

    localparam int c_REG2LOC  = 0;
    localparam int c_ALUSRC   = 1;
    localparam int c_MEMTOREG = 2;
    localparam int c_REGWRITE = 3;
    localparam int c_MEMWRITE = 4;
    localparam int c_UNCONDBR = 8;
    localparam int c_BRTAKEN  = 9;
    localparam int c_SETFLAGS = 10;
    localparam int c_IMMSEL   = 11;
    localparam int c_MEMREAD  = 12;

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b011;
    localparam logic [2:0] c_ALU_AND = 3'b100;
    localparam logic [2:0] c_ALU_XOR = 3'b110;

    localparam logic [10:0] c_OP_ADD   = 11'b10001011000;
    localparam logic [10:0] c_OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] c_OP_AND   = 11'b10001010000;
    localparam logic [10:0] c_OP_EOR   = 11'b11001010000;
    localparam logic [10:0] c_OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] c_OP_ADDI  = 11'b1001000100?;
    localparam logic [10:0] c_OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] c_OP_STUR  = 11'b11111000000;
    localparam logic [10:0] c_OP_B     = 11'b000101?????;
    localparam logic [10:0] c_OP_BCOND = 11'b01010100???;
    localparam logic [10:0] c_OP_CBZ   = 11'b10110100???;

    logic [19:0] r_cntrl_ex;
    logic [3:0]  r_flags;
    logic [4:0]  r_rd_ex;
    logic        r_memread_ex;

    logic [19:0] w_dec;
    logic [19:0] w_cntrl;
    logic        w_uses_rn;
    logic        w_uses_rm;
    logic        w_uses_rt;
    logic        w_is_bcond;
    logic        w_cond_taken;
    logic [3:0]  w_cond_flags;
    logic        w_flag_stall;
    logic        w_load_use;
    logic        w_stall;
    logic        w_unused_bits;

    // Immediate/offset fields are consumed downstream, not by this block.
    assign w_unused_bits = ^bus.instr[15:10];

`ifdef FLAG_FWD_EN
    assign w_cond_flags = r_cntrl_ex[c_SETFLAGS] ? bus.ex_flags : r_flags;
    assign w_flag_stall = 1'b0;
`else
    assign w_cond_flags = r_flags;
    assign w_flag_stall = w_is_bcond & r_cntrl_ex[c_SETFLAGS];
`endif

    // NZCV: [3]=N [2]=Z [1]=C [0]=V
    always_comb begin
        w_cond_taken = 1'b0;
        case (bus.instr[3:0])
            4'b0000: w_cond_taken = w_cond_flags[2];
            4'b0001: w_cond_taken = ~w_cond_flags[2];
            4'b1010: w_cond_taken = (w_cond_flags[3] == w_cond_flags[0]);
            4'b1011: w_cond_taken = (w_cond_flags[3] != w_cond_flags[0]);
            4'b1100: w_cond_taken = ~w_cond_flags[2] & (w_cond_flags[3] == w_cond_flags[0]);
            4'b1101: w_cond_taken = w_cond_flags[2] | (w_cond_flags[3] != w_cond_flags[0]);
            default: w_cond_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_dec      = '0;
        w_uses_rn  = 1'b0;
        w_uses_rm  = 1'b0;
        w_uses_rt  = 1'b0;
        w_is_bcond = 1'b0;
        casez (bus.instr[31:21])
            c_OP_ADD, c_OP_ADDS, c_OP_AND, c_OP_EOR, c_OP_SUBS: begin
                w_uses_rn          = 1'b1;
                w_uses_rm          = 1'b1;
                w_dec[c_REGWRITE]  = 1'b1;
                w_dec[c_SETFLAGS]  = (bus.instr[31:21] == c_OP_ADDS) ||
                                     (bus.instr[31:21] == c_OP_SUBS);
                if (bus.instr[31:21] == c_OP_AND)
                    w_dec[7:5] = c_ALU_AND;
                else if (bus.instr[31:21] == c_OP_EOR)
                    w_dec[7:5] = c_ALU_XOR;
                else if (bus.instr[31:21] == c_OP_SUBS)
                    w_dec[7:5] = c_ALU_SUB;
                else
                    w_dec[7:5] = c_ALU_ADD;
            end
            c_OP_ADDI: begin
                w_uses_rn         = 1'b1;
                w_dec[c_ALUSRC]   = 1'b1;
                w_dec[c_REGWRITE] = 1'b1;
                w_dec[c_IMMSEL]   = 1'b1;
                w_dec[7:5]        = c_ALU_ADD;
            end
            c_OP_LDUR: begin
                w_uses_rn         = 1'b1;
                w_dec[c_ALUSRC]   = 1'b1;
                w_dec[c_MEMTOREG] = 1'b1;
                w_dec[c_REGWRITE] = 1'b1;
                w_dec[c_MEMREAD]  = 1'b1;
                w_dec[7:5]        = c_ALU_ADD;
            end
            c_OP_STUR: begin
                w_uses_rn         = 1'b1;
                w_uses_rt         = 1'b1;
                w_dec[c_REG2LOC]  = 1'b1;
                w_dec[c_ALUSRC]   = 1'b1;
                w_dec[c_MEMWRITE] = 1'b1;
                w_dec[7:5]        = c_ALU_ADD;
            end
            c_OP_B: begin
                w_dec[c_UNCONDBR] = 1'b1;
                w_dec[c_BRTAKEN]  = 1'b1;
            end
            c_OP_BCOND: begin
                w_is_bcond       = 1'b1;
                w_dec[c_BRTAKEN] = w_cond_taken;
            end
            c_OP_CBZ: begin
                w_uses_rt        = 1'b1;
                w_dec[c_REG2LOC] = 1'b1;
                w_dec[c_BRTAKEN] = bus.rt_zero;
            end
            default: ;
        endcase
    end

    // X31 is the zero register, so a load into it never creates a hazard.
    assign w_load_use = r_memread_ex && (r_rd_ex != 5'd31) &&
                        ((w_uses_rn && (bus.instr[9:5]   == r_rd_ex)) ||
                         (w_uses_rm && (bus.instr[20:16] == r_rd_ex)) ||
                         (w_uses_rt && (bus.instr[4:0]   == r_rd_ex)));

    assign w_stall = w_load_use | w_flag_stall;
    assign w_cntrl = w_stall ? '0 : w_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cntrl_ex   <= '0;
            r_flags      <= '0;
            r_rd_ex      <= 5'd31;
            r_memread_ex <= 1'b0;
        end else begin
            r_cntrl_ex <= w_cntrl;
            if (r_cntrl_ex[c_SETFLAGS])
                r_flags <= bus.ex_flags;
            // Clearing the EX tracking on a bubble bounds every stall to one cycle.
            if (w_stall) begin
                r_rd_ex      <= 5'd0;
                r_memread_ex <= 1'b0;
            end else begin
                r_rd_ex      <= bus.instr[4:0];
                r_memread_ex <= w_cntrl[c_MEMREAD];
            end
        end
    end

    assign bus.cntrl    = w_cntrl;
    assign bus.cntrl_ex = r_cntrl_ex;
    assign bus.flags    = r_flags;
    assign bus.stall    = w_stall;

endmodule

`default_nettype wire

// File: tb/tb_instr_decode_ctrl.sv
// ============================================================================
// Module      : tb_instr_decode_ctrl
// Description : Directed table-driven bench for instr_decode_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_decode_ctrl;

    typedef struct packed {
        logic [31:0] instr;
        logic        rt_zero;
        logic [19:0] exp_cntrl;
    } vec_t;

    typedef struct packed {
        logic [31:0] ld;
        logic [31:0] user;
        logic        exp_stall;
        logic [19:0] user_cntrl;
    } pair_t;

    localparam int c_NVEC  = 20;
    localparam int c_NPAIR = 9;
    localparam logic [31:0] c_NOP = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t  vecs  [c_NVEC];
    pair_t pairs [c_NPAIR];

    instr_decode_ctrl_if dec_if ();

    instr_decode_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dec_if.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{32'h8B010003, 1'b0, 20'h00048};  // ADD
        vecs[1]  = '{32'hAB020020, 1'b0, 20'h00448};  // ADDS
        vecs[2]  = '{32'h8A020020, 1'b0, 20'h00088};  // AND
        vecs[3]  = '{32'hCA020020, 1'b0, 20'h000C8};  // EOR
        vecs[4]  = '{32'hEB030041, 1'b0, 20'h00468};  // SUBS
        vecs[5]  = '{32'h91000420, 1'b0, 20'h0084A};  // ADDI
        vecs[6]  = '{32'hF8400022, 1'b0, 20'h0104E};  // LDUR
        vecs[7]  = '{32'hF8000022, 1'b0, 20'h00053};  // STUR
        vecs[8]  = '{32'h14000004, 1'b0, 20'h00300};  // B
        vecs[9]  = '{32'hB4000045, 1'b1, 20'h00201};  // CBZ taken
        vecs[10] = '{32'hB4000045, 1'b0, 20'h00001};  // CBZ not taken
        vecs[11] = '{32'h54000000, 1'b0, 20'h00000};  // B.EQ, flags 0000
        vecs[12] = '{32'h54000001, 1'b0, 20'h00200};  // B.NE
        vecs[13] = '{32'h5400000A, 1'b0, 20'h00200};  // B.GE
        vecs[14] = '{32'h5400000B, 1'b0, 20'h00000};  // B.LT
        vecs[15] = '{32'h5400000C, 1'b0, 20'h00200};  // B.GT
        vecs[16] = '{32'h5400000D, 1'b0, 20'h00000};  // B.LE
        vecs[17] = '{32'h5400000E, 1'b0, 20'h00000};  // unsupported cond
        vecs[18] = '{32'h00000000, 1'b1, 20'h00000};  // unknown
        vecs[19] = '{32'hFFFFFFFF, 1'b1, 20'h00000};  // unknown

        pairs[0] = '{32'hF8400022, 32'h8B000043, 1'b1, 20'h00048};  // Rn hit
        pairs[1] = '{32'hF8400022, 32'h8B020003, 1'b1, 20'h00048};  // Rm hit
        pairs[2] = '{32'hF840003F, 32'h8B0003E3, 1'b0, 20'h00048};  // X31 load
        pairs[3] = '{32'hF8400022, 32'hF8000022, 1'b1, 20'h00053};  // STUR Rt
        pairs[4] = '{32'hF8400025, 32'hB4000045, 1'b1, 20'h00201};  // CBZ Rt
        pairs[5] = '{32'hF8400022, 32'h91000440, 1'b1, 20'h0084A};  // ADDI Rn
        pairs[6] = '{32'hF8400022, 32'h14000042, 1'b0, 20'h00300};  // B no src
        pairs[7] = '{32'h8B000002, 32'h8B000043, 1'b0, 20'h00048};  // not a load
        pairs[8] = '{32'hF8400023, 32'hCA020023, 1'b0, 20'h000C8};  // dest only

        reset           = 1'b1;
        dec_if.instr    = c_NOP;
        dec_if.ex_flags = 4'b0000;
        dec_if.rt_zero  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset cntrl_ex", 32'(dec_if.cntrl_ex), 32'h0);
        check("reset flags", 32'(dec_if.flags), 32'h0);
        #4;
        check("reset stall", 32'(dec_if.stall), 32'h0);

        for (int i = 0; i < c_NVEC; i++) begin
            tick();
            dec_if.instr   = c_NOP;
            tick();
            dec_if.instr   = vecs[i].instr;
            dec_if.rt_zero = vecs[i].rt_zero;
            #4;
            check($sformatf("vec%0d cntrl", i), 32'(dec_if.cntrl), 32'(vecs[i].exp_cntrl));
            check($sformatf("vec%0d stall", i), 32'(dec_if.stall), 32'h0);
            tick();
            check($sformatf("vec%0d cntrl_ex", i), 32'(dec_if.cntrl_ex), 32'(vecs[i].exp_cntrl));
        end
        check("flags after table", 32'(dec_if.flags), 32'h0);

        dec_if.rt_zero = 1'b1;
        for (int i = 0; i < c_NPAIR; i++) begin
            dec_if.instr = c_NOP;
            tick();
            dec_if.instr = pairs[i].ld;
            #4;
            check($sformatf("pair%0d load stall", i), 32'(dec_if.stall), 32'h0);
            tick();
            dec_if.instr = pairs[i].user;
            #4;
            check($sformatf("pair%0d stall", i), 32'(dec_if.stall), 32'(pairs[i].exp_stall));
            check($sformatf("pair%0d cntrl", i), 32'(dec_if.cntrl),
                  pairs[i].exp_stall ? 32'h0 : 32'(pairs[i].user_cntrl));
            tick();
            check($sformatf("pair%0d cntrl_ex", i), 32'(dec_if.cntrl_ex),
                  pairs[i].exp_stall ? 32'h0 : 32'(pairs[i].user_cntrl));
            #4;
            check($sformatf("pair%0d stall after", i), 32'(dec_if.stall), 32'h0);
            check($sformatf("pair%0d cntrl after", i), 32'(dec_if.cntrl), 32'(pairs[i].user_cntrl));
            tick();
        end
        dec_if.rt_zero = 1'b0;

        // SUBS immediately followed by B.LT with EX flags N=1
        dec_if.instr = c_NOP;
        tick();
        dec_if.instr = 32'hEB030041;
        #4;
        check("subs cntrl", 32'(dec_if.cntrl), 32'h468);
        tick();
        dec_if.instr    = 32'h5400004B;
        dec_if.ex_flags = 4'b1000;
        #4;
`ifdef FLAG_FWD_EN
        check("blt fwd stall", 32'(dec_if.stall), 32'h0);
        check("blt fwd cntrl", 32'(dec_if.cntrl), 32'h200);
`else
        check("blt stall", 32'(dec_if.stall), 32'h1);
        check("blt bubble cntrl", 32'(dec_if.cntrl), 32'h0);
`endif
        tick();
        dec_if.ex_flags = 4'b0101;
        check("flags after subs", 32'(dec_if.flags), 32'h8);
        #4;
        check("blt second stall", 32'(dec_if.stall), 32'h0);
        check("blt second cntrl", 32'(dec_if.cntrl), 32'h200);
        tick();
        dec_if.instr = c_NOP;
        tick();
        tick();
        check("flags hold", 32'(dec_if.flags), 32'h8);

        // ADDS producing Z=1, then conditions evaluated on the register
        dec_if.instr = 32'hAB020020;
        tick();
        dec_if.instr    = c_NOP;
        dec_if.ex_flags = 4'b0100;
        tick();
        dec_if.ex_flags = 4'b0000;
        check("flags after adds", 32'(dec_if.flags), 32'h4);
        dec_if.instr = 32'h54000000;
        #2;
        check("beq Z", 32'(dec_if.cntrl), 32'h200);
        dec_if.instr = 32'h5400000C;
        #1;
        check("bgt Z", 32'(dec_if.cntrl), 32'h0);
        dec_if.instr = 32'h5400000D;
        #1;
        check("ble Z", 32'(dec_if.cntrl), 32'h200);
        dec_if.instr = 32'h54000001;
        #1;
        check("bne Z", 32'(dec_if.cntrl), 32'h0);

        // Unconditional branch
        tick();
        dec_if.instr    = 32'h14000004;
        dec_if.ex_flags = 4'b1111;
        #4;
        check("b br bits", 32'(dec_if.cntrl[9:8]), 32'h3);
        check("b stall", 32'(dec_if.stall), 32'h0);
        tick();
        tick();
        check("b flags", 32'(dec_if.flags), 32'h4);
        dec_if.ex_flags = 4'b0000;

        // Reset arriving while a load-use bubble is pending
        dec_if.instr = c_NOP;
        tick();
        dec_if.instr = 32'hF8400022;
        tick();
        dec_if.instr = 32'h8B000043;
        #4;
        check("rst-stall stall", 32'(dec_if.stall), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst-stall cntrl_ex", 32'(dec_if.cntrl_ex), 32'h0);
        check("rst-stall flags", 32'(dec_if.flags), 32'h0);
        #4;
        check("rst-stall after stall", 32'(dec_if.stall), 32'h0);
        check("rst-stall after cntrl", 32'(dec_if.cntrl), 32'h48);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_decode_ctrl.md
INSTR_DECODE_CTRL -- requirements
Module: instr_decode_ctrl

Interface
REQ-001 Clock: one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising clk.
REQ-004 instr  input  32  registered instruction currently in decode (fetch-stage output).
REQ-005 ex_flags  input  4  NZCV from EX-stage ALU, valid in the same cycle as cntrl_ex.
REQ-006 rt_zero  input  1  register-file read of Rt (instr[4:0]) equals zero, for CBZ.
REQ-007 cntrl  output  20  combinational control word for instr; consumed by fetch in the same cycle.
REQ-008 cntrl_ex  output  20  registered copy of cntrl, i.e. EX-stage control.
REQ-009 flags  output  4  architectural NZCV register.
REQ-010 stall  output  1  decode-stage bubble inserted this cycle.

Function
REQ-011 cntrl bit map: [0] Reg2Loc, [1] ALUSrc, [2] MemToReg, [3] RegWrite, [4] MemWrite, [7:5] ALUOp (000 pass-B, 010 ADD, 011 SUB, 100 AND, 110 XOR), [8] UncondBr, [9] BrTaken, [10] SetFlags, [11] ImmSel (1 = ADDI imm12, 0 = D-type imm9), [12] MemRead, [19:13] constant 0.
REQ-012 Decoded opcodes: ADD 10001011000, ADDS 10101011000, AND 10001010000, EOR 11001010000, SUBS 11101011000, ADDI 1001000100 ([31:22]), LDUR 11111000010, STUR 11111000000, B 000101 ([31:26]), B.cond 01010100 ([31:24]), CBZ 10110100 ([31:24]).
REQ-013 Any unrecognised encoding produces cntrl = 0 (NOP); it never asserts stall.
REQ-014 B: BrTaken=1, UncondBr=1; all other bits 0.
REQ-015 CBZ: UncondBr=0, BrTaken=rt_zero, Reg2Loc=1.
REQ-016 B.cond: UncondBr=0, BrTaken=condition instr[3:0] evaluated on the selected flags; supported EQ(0000), NE(0001), GE(1010), LT(1011), GT(1100), LE(1101); other codes never taken.
REQ-017 STUR: Reg2Loc=1, ALUSrc=1, MemWrite=1, ALUOp=ADD; LDUR: ALUSrc=1, MemToReg=1, RegWrite=1, MemRead=1, ALUOp=ADD.
REQ-018 ADDS and SUBS set SetFlags=1; no other instruction sets it.
REQ-019 Every clk edge: cntrl_ex <= cntrl, where cntrl is already forced to 0 on stall.
REQ-020 Every clk edge with cntrl_ex[10]=1: flags <= ex_flags; otherwise flags holds.
REQ-021 Load-use hazard: internal rd_ex (instr[4:0] registered) and memread_ex; stall=1 when memread_ex=1, rd_ex!=31, and rd_ex matches a source of instr (Rn[9:5] for ALU/mem ops; Rm[20:16] for R-type; Rt[4:0] for STUR/CBZ).
REQ-022 On stall: cntrl=0 (BrTaken=0), and rd_ex/memread_ex load 0, so a stall lasts exactly one cycle.
REQ-023 Branch delay slot: the instruction after a taken branch executes; no flush is performed.

Reset
REQ-024 While reset=1 at a clk edge: cntrl_ex=0, flags=0000, rd_ex=31, memread_ex=0; stall=0 in the following cycle.
REQ-025 Reset during a stall cycle discards the pending hazard; the next cycle does not stall.

Configuration
REQ-026 Macro FLAG_FWD_EN defined: B.cond uses ex_flags when cntrl_ex[10]=1, else flags; no flag stall.
REQ-027 FLAG_FWD_EN undefined: B.cond while cntrl_ex[10]=1 sets stall=1 for one cycle, then evaluates on the updated flags.

Verification
REQ-028 Reset asserted 2 cycles -> cntrl_ex=0, flags=0000, stall=0.
REQ-029 instr=0x8B010003 (ADD X3,X1,X0) -> cntrl=0x048 (RegWrite, ALUOp=ADD); next cycle cntrl_ex=0x048.
REQ-030 instr=0xF8400022 (LDUR X2,[X1]), then 0x8B000043 (ADD X3,X2,X0) -> stall=1, cntrl=0 for one cycle; next cycle stall=0, cntrl=0x048.
REQ-031 SUBS then 0x5400004B (B.LT) with ex_flags=1000 -> with FLAG_FWD_EN, BrTaken=1 in the first cycle; without it, stall=1 in the first cycle, BrTaken=1 in the second, and flags=1000.
REQ-032 CBZ with rt_zero=1 -> cntrl[9:8]=10; with rt_zero=0 -> cntrl[9:8]=00.
REQ-033 B (instr=0x14000004) -> cntrl[9:8]=11, with no stall and no change to flags.
